// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared types and constants for the N:1 packet stream mux
package mux_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    localparam int DEF_N_CH  = 4;
    localparam int DEF_WIDTH = 8;

    // Select-bus width; never narrower than one bit.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/stream_reg_slice.sv
// rtl/stream_reg_slice.sv - single-entry registered stream slice with pass-through ready
module stream_reg_slice #(
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [PW-1:0] s_tdata_i,
    input  logic          s_tvalid_i,
    output logic          s_tready_o,
    output logic [PW-1:0] m_tdata_o,
    output logic          m_tvalid_o,
    input  logic          m_tready_i
);

    logic [PW-1:0] data_q;
    logic          valid_q;

    // Free when empty or draining this cycle, so full throughput needs no bubble.
    assign s_tready_o = !valid_q || m_tready_i;
    assign m_tdata_o  = data_q;
    assign m_tvalid_o = valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (s_tvalid_i && s_tready_o) begin
            data_q  <= s_tdata_i;
            valid_q <= 1'b1;
        end else if (m_tready_i) begin
            valid_q <= 1'b0;
        end
    end

endmodule

// File: rtl/mux_nx1_stream.sv
// rtl/mux_nx1_stream.sv - N:1 packet-locked stream multiplexer with registered output
module mux_nx1_stream
    import mux_pkg::*;
#(
    parameter int  N_CH  = DEF_N_CH,
    parameter int  WIDTH = DEF_WIDTH,
    localparam int SW    = sel_width(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [SW-1:0]         sel,
    input  logic [N_CH*WIDTH-1:0] in_data,
    input  logic [N_CH-1:0]       in_valid,
    input  logic [N_CH-1:0]       in_last,
    output logic [N_CH-1:0]       in_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    output logic                  out_last,
    output logic [SW-1:0]         out_ch,
    input  logic                  out_ready,
    output logic                  busy
);

    localparam int          PW     = WIDTH + 1 + SW;
    localparam logic [SW:0] N_CH_W = (SW + 1)'(N_CH);

    state_t          state_q, state_d;
    logic [SW-1:0]   locked_ch_q, locked_ch_d;
    logic            can_load;
    logic            sel_ok;
    logic            ch_open;
    logic [SW-1:0]   cur_ch;
    logic [WIDTH-1:0] mux_data;
    logic            mux_last;
    logic            mux_valid;
    logic            accept;
    logic [PW-1:0]   slice_out;

    assign sel_ok  = {1'b0, sel} < N_CH_W;
    assign cur_ch  = (state_q == ST_LOCKED) ? locked_ch_q : sel;
    // Owner may move only when the output slot can take a beat; nothing moves in reset.
    assign ch_open = !rst && can_load && ((state_q == ST_LOCKED) || sel_ok);

    always_comb begin
        in_ready  = '0;
        mux_data  = '0;
        mux_last  = 1'b0;
        mux_valid = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (cur_ch == SW'(i)) begin
                in_ready[i] = ch_open;
                mux_data    = in_data[i*WIDTH +: WIDTH];
                mux_last    = in_last[i];
                mux_valid   = in_valid[i];
            end
        end
    end

    assign accept = mux_valid && ch_open;

    always_comb begin
        state_d     = state_q;
        locked_ch_d = locked_ch_q;
        case (state_q)
            ST_IDLE: begin
                if (accept && !mux_last) begin
                    state_d     = ST_LOCKED;
                    locked_ch_d = sel;
                end
            end
            ST_LOCKED: begin
                if (accept && mux_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            locked_ch_q <= '0;
        end else begin
            state_q     <= state_d;
            locked_ch_q <= locked_ch_d;
        end
    end

    assign busy = (state_q == ST_LOCKED);

    stream_reg_slice #(
        .PW(PW)
    ) u_out_slice (
        .clk        (clk),
        .rst        (rst),
        .s_tdata_i  ({mux_last, cur_ch, mux_data}),
        .s_tvalid_i (accept),
        .s_tready_o (can_load),
        .m_tdata_o  (slice_out),
        .m_tvalid_o (out_valid),
        .m_tready_i (out_ready)
    );

    assign out_data = slice_out[WIDTH-1:0];
    assign out_ch   = slice_out[WIDTH +: SW];
    assign out_last = slice_out[PW-1];

endmodule

// File: tb/tb_mux_nx1_stream.sv
// tb/tb_mux_nx1_stream.sv - self-checking bench for mux_nx1_stream across several parameter sets
module tb_mux_nx1_stream;

    localparam int NI = 4;
    localparam int NCH_T[NI] = '{2, 4, 16, 3};
    localparam int W_T[NI]   = '{1, 8, 64, 8};
    localparam int DK = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [63:0] d_data [NI][16];
    logic [15:0] d_valid[NI];
    logic [15:0] d_last [NI];
    logic [3:0]  d_sel  [NI];
    logic        d_ordy [NI];

    logic [63:0] o_data [NI];
    logic [3:0]  o_ch   [NI];
    logic        o_valid[NI];
    logic        o_last [NI];
    logic        o_busy [NI];
    logic [15:0] o_irdy [NI];

    int n_checks = 0;
    int n_errors = 0;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int N = NCH_T[g];
        localparam int W = W_T[g];
        localparam int S = (N > 1) ? $clog2(N) : 1;
        logic [N*W-1:0] in_data;
        logic [N-1:0]   in_ready;
        logic [W-1:0]   out_data;
        logic [S-1:0]   out_ch;
        logic           ov, ol, bz;
        for (genvar c = 0; c < N; c++) begin : g_ch
            assign in_data[c*W +: W] = d_data[g][c][W-1:0];
        end
        mux_nx1_stream #(.N_CH(N), .WIDTH(W)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .sel       (d_sel[g][S-1:0]),
            .in_data   (in_data),
            .in_valid  (d_valid[g][N-1:0]),
            .in_last   (d_last[g][N-1:0]),
            .in_ready  (in_ready),
            .out_data  (out_data),
            .out_valid (ov),
            .out_last  (ol),
            .out_ch    (out_ch),
            .out_ready (d_ordy[g]),
            .busy      (bz)
        );
        assign o_data[g]  = 64'(out_data);
        assign o_ch[g]    = 4'(out_ch);
        assign o_valid[g] = ov;
        assign o_last[g]  = ol;
        assign o_busy[g]  = bz;
        assign o_irdy[g]  = 16'(in_ready);
    end

    task automatic clear_all();
        for (int k = 0; k < NI; k++) begin
            for (int c = 0; c < 16; c++) d_data[k][c] = '0;
            d_valid[k] = '0;
            d_last[k]  = '0;
            d_sel[k]   = '0;
            d_ordy[k]  = 1'b1;
        end
    endtask

    task automatic settle();
        clear_all();
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if ({o_valid[DK], o_last[DK], o_busy[DK], o_ch[DK], o_data[DK], o_irdy[DK]} !== '0) begin
            n_errors++;
            $display("FAIL reset_init: valid=%0b last=%0b busy=%0b ch=%0d data=%h ready=%b, required all 0",
                     o_valid[DK], o_last[DK], o_busy[DK], o_ch[DK], o_data[DK], o_irdy[DK]);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        d_sel[DK] = 0; d_data[DK][0] = 64'h77; d_valid[DK][0] = 1'b1; d_ordy[DK] = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (o_busy[DK] !== 1'b1 || o_valid[DK] !== 1'b1 || o_data[DK] !== 64'h77) begin
            n_errors++;
            $display("FAIL reset_pre: busy=%0b valid=%0b data=%h, required 1 1 77", o_busy[DK], o_valid[DK], o_data[DK]);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({o_valid[DK], o_last[DK], o_busy[DK], o_ch[DK], o_data[DK], o_irdy[DK]} !== '0) begin
            n_errors++;
            $display("FAIL reset_mid: valid=%0b busy=%0b data=%h ready=%b, required all 0",
                     o_valid[DK], o_busy[DK], o_data[DK], o_irdy[DK]);
        end
        clear_all();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (o_busy[DK] !== 1'b0 || o_valid[DK] !== 1'b0 || o_irdy[DK] !== 16'h0001) begin
            n_errors++;
            $display("FAIL reset_release: busy=%0b valid=%0b ready=%b, required 0 0 0001", o_busy[DK], o_valid[DK], o_irdy[DK]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_beat();
        settle();
        d_sel[DK] = 2; d_data[DK][2] = 64'hA5; d_valid[DK][2] = 1'b1; d_last[DK][2] = 1'b1;
        @(posedge clk);
        #1;
        d_valid[DK] = '0;
        n_checks++;
        if (o_valid[DK] !== 1'b1 || o_data[DK] !== 64'hA5 || o_ch[DK] !== 4'd2 || o_last[DK] !== 1'b1 || o_busy[DK] !== 1'b0) begin
            n_errors++;
            $display("FAIL single_beat: valid=%0b data=%h ch=%0d last=%0b busy=%0b, required 1 a5 2 1 0",
                     o_valid[DK], o_data[DK], o_ch[DK], o_last[DK], o_busy[DK]);
        end
    endtask

    task automatic test_lock();
        settle();
        d_sel[DK] = 1;
        d_valid[DK] = 16'b1010;
        d_data[DK][1] = 64'h11; d_last[DK][1] = 1'b0;
        d_data[DK][3] = 64'h33; d_last[DK][3] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (o_irdy[DK] !== 16'b0010) begin
                n_errors++;
                $display("FAIL lock_ready beat %0d: ready=%b, required 0010", i, o_irdy[DK]);
            end
            @(posedge clk);
            #1;
            n_checks++;
            if (o_valid[DK] !== 1'b1 || o_data[DK] !== 64'(8'h11 + i) || o_ch[DK] !== 4'd1 || o_last[DK] !== (i == 2)) begin
                n_errors++;
                $display("FAIL lock_beat %0d: valid=%0b data=%h ch=%0d last=%0b, required 1 %h 1 %0b",
                         i, o_valid[DK], o_data[DK], o_ch[DK], o_last[DK], 8'h11 + i, i == 2);
            end
            d_sel[DK] = 3;
            d_data[DK][1] = 64'(8'h12 + i);
            d_last[DK][1] = (i == 1);
            if (i == 2) d_valid[DK][1] = 1'b0;
        end
        @(negedge clk);
        n_checks++;
        if (o_irdy[DK] !== 16'b1000 || o_busy[DK] !== 1'b0) begin
            n_errors++;
            $display("FAIL lock_release: ready=%b busy=%0b, required 1000 0", o_irdy[DK], o_busy[DK]);
        end
        @(posedge clk);
        #1;
        d_valid[DK] = '0;
        n_checks++;
        if (o_data[DK] !== 64'h33 || o_ch[DK] !== 4'd3 || o_last[DK] !== 1'b1) begin
            n_errors++;
            $display("FAIL lock_next_ch: data=%h ch=%0d last=%0b, required 33 3 1", o_data[DK], o_ch[DK], o_last[DK]);
        end
    endtask

    task automatic test_backpressure();
        settle();
        d_sel[DK] = 0; d_data[DK][0] = 64'h5A; d_valid[DK][0] = 1'b1; d_last[DK][0] = 1'b1; d_ordy[DK] = 1'b0;
        @(posedge clk);
        #1;
        d_data[DK][0] = 64'h60;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if (o_valid[DK] !== 1'b1 || o_data[DK] !== 64'h5A || o_irdy[DK] !== 16'h0) begin
                n_errors++;
                $display("FAIL bp_hold %0d: valid=%0b data=%h ready=%b, required 1 5a 0", i, o_valid[DK], o_data[DK], o_irdy[DK]);
            end
        end
        @(posedge clk);
        #1 d_ordy[DK] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            d_data[DK][0] = 64'(8'h60 + i);
            @(posedge clk);
            #1;
            n_checks++;
            if (o_valid[DK] !== 1'b1 || o_data[DK] !== 64'(8'h60 + i)) begin
                n_errors++;
                $display("FAIL bp_stream %0d: valid=%0b data=%h, required 1 %h", i, o_valid[DK], o_data[DK], 8'h60 + i);
            end
        end
        d_valid[DK] = '0;
        @(posedge clk);
        #1;
        n_checks++;
        if (o_valid[DK] !== 1'b0) begin
            n_errors++;
            $display("FAIL bp_drain: valid=%0b, required 0", o_valid[DK]);
        end
    endtask

    task automatic test_invalid_sel();
        settle();
        d_sel[3] = 3; d_valid[3] = 16'h7; d_last[3] = 16'h7;
        d_data[3][0] = 64'h1; d_data[3][1] = 64'h2; d_data[3][2] = 64'h3;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (o_irdy[3] !== 16'h0 || o_valid[3] !== 1'b0 || o_busy[3] !== 1'b0) begin
                n_errors++;
                $display("FAIL invalid_sel %0d: ready=%b valid=%0b busy=%0b, required 0 0 0", i, o_irdy[3], o_valid[3], o_busy[3]);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_random(input int k);
        int          n, w, total, got, cyc, lock, open_ch, c;
        logic [63:0] mask;
        logic [63:0] gdata[16][16];
        bit          glast[16][16];
        int          nbeats[16], sptr[16], optr[16];
        logic [15:0] irdy, exp_irdy, acc;
        logic        ov, ordy;
        settle();
        n = NCH_T[k];
        w = W_T[k];
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        total = 0;
        for (int ch = 0; ch < n; ch++) begin
            nbeats[ch] = 0; sptr[ch] = 0; optr[ch] = 0;
            for (int p = 0; p < 3; p++) begin
                int len = $urandom_range(1, 4);
                for (int b = 0; b < len; b++) begin
                    gdata[ch][nbeats[ch]] = {$urandom, $urandom} & mask;
                    glast[ch][nbeats[ch]] = (b == len - 1);
                    nbeats[ch]++;
                end
            end
            total += nbeats[ch];
        end
        got = 0; cyc = 0; lock = -1; open_ch = -1;
        while (got < total && cyc < 4000) begin
            cyc++;
            for (int ch = 0; ch < n; ch++) begin
                if (sptr[ch] < nbeats[ch]) begin
                    d_valid[k][ch] = ($urandom_range(0, 3) != 0);
                    d_data[k][ch]  = gdata[ch][sptr[ch]];
                    d_last[k][ch]  = glast[ch][sptr[ch]];
                end else begin
                    d_valid[k][ch] = 1'b0;
                end
            end
            d_sel[k]  = 4'($urandom_range(0, n - 1));
            d_ordy[k] = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            irdy = o_irdy[k];
            ov = o_valid[k];
            ordy = d_ordy[k];
            if (!ov || ordy) exp_irdy = (lock >= 0) ? (16'd1 << lock) : (16'd1 << d_sel[k]);
            else exp_irdy = '0;
            n_checks++;
            if (irdy !== exp_irdy || o_busy[k] !== (lock >= 0)) begin
                n_errors++;
                $display("FAIL rand%0d_ready cyc %0d: ready=%b busy=%0b, required %b %0b", k, cyc, irdy, o_busy[k], exp_irdy, lock >= 0);
            end
            if (ov && ordy) begin
                c = int'(o_ch[k]);
                n_checks++;
                if (c >= n || optr[c] >= nbeats[c]) begin
                    n_errors++;
                    $display("FAIL rand%0d_extra cyc %0d: ch=%0d, required a pending channel", k, cyc, c);
                end else begin
                    if (o_data[k] !== gdata[c][optr[c]] || o_last[k] !== glast[c][optr[c]]) begin
                        n_errors++;
                        $display("FAIL rand%0d_beat ch %0d idx %0d: data=%h last=%0b, required %h %0b",
                                 k, c, optr[c], o_data[k], o_last[k], gdata[c][optr[c]], glast[c][optr[c]]);
                    end
                    optr[c]++;
                    got++;
                    n_checks++;
                    if (open_ch >= 0 && c != open_ch) begin
                        n_errors++;
                        $display("FAIL rand%0d_interleave: ch=%0d, required %0d", k, c, open_ch);
                    end
                    open_ch = o_last[k] ? -1 : c;
                end
            end
            acc = d_valid[k] & irdy;
            for (int ch = 0; ch < n; ch++) begin
                if (acc[ch]) begin
                    lock = d_last[k][ch] ? -1 : ch;
                    sptr[ch]++;
                end
            end
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (got != total) begin
            n_errors++;
            $display("FAIL rand%0d_complete: delivered=%0d, required %0d", k, got, total);
        end
        settle();
    endtask

    initial begin
        rst = 1'b1;
        clear_all();
        test_reset();
        test_single_beat();
        test_lock();
        test_backpressure();
        test_invalid_sel();
        for (int k = 0; k < 3; k++) test_random(k);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mux_nx1_stream.md
MUX_NX1_STREAM -- requirements
Module: mux_nx1_stream

Interface
REQ-001 Parameter N_CH, default 4, number of input channels (2..16).
REQ-002 Parameter WIDTH, default 8, data bits per channel (1..64).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous assert, active-high.
REQ-005 sel  input  SW=$clog2(N_CH)  requested channel; sampled only in IDLE.
REQ-006 in_data  input  N_CH*WIDTH  channel i data at bits [i*WIDTH +: WIDTH].
REQ-007 in_valid  input  N_CH  per-channel beat valid.
REQ-008 in_last  input  N_CH  per-channel end-of-packet marker.
REQ-009 in_ready  output  N_CH  per-channel accept.
REQ-010 out_data  output  WIDTH  registered data.
REQ-011 out_valid  output  1  out_data/out_last/out_ch valid.
REQ-012 out_last  output  1  registered end-of-packet.
REQ-013 out_ch  output  SW  channel index of the held beat.
REQ-014 out_ready  input  1  downstream accept.
REQ-015 busy  output  1  high in LOCKED state.

Function
REQ-016 Transfer on input i: in_valid[i] && in_ready[i] at rising edge; output transfer: out_valid && out_ready.
REQ-017 States: IDLE, LOCKED; locked_ch register holds the owning channel.
REQ-018 Slot free: can_load = !out_valid || out_ready (no bubble at full throughput).
REQ-019 IDLE: in_ready[sel] = can_load when sel < N_CH; all other in_ready bits 0.
REQ-020 IDLE, sel >= N_CH: all in_ready 0, no transfer, state unchanged.
REQ-021 IDLE, accepted beat with in_last=0: go LOCKED, locked_ch <= sel.
REQ-022 IDLE, accepted beat with in_last=1: stay IDLE (single-beat packet).
REQ-023 LOCKED: in_ready[locked_ch] = can_load, all others 0; sel ignored.
REQ-024 LOCKED, accepted beat with in_last=1: return IDLE next cycle.
REQ-025 Accepted beat appears on out_data/out_last/out_ch one cycle later (latency 1).
REQ-026 out_valid holds and out_data/out_last/out_ch remain stable while out_valid && !out_ready.
REQ-027 Simultaneous output accept and new input accept: register reloads, out_valid stays 1.
REQ-028 Output accept with no input accept: out_valid <= 0 next cycle.
REQ-029 in_ready is combinational from state, sel, out_valid, out_ready; no dependency on in_valid.
REQ-030 Beats are never dropped, duplicated or interleaved between channels within a packet.

Reset
REQ-031 rst asserted: state IDLE, locked_ch 0, out_valid 0, out_data 0, out_last 0, out_ch 0, busy 0, immediately without clock.
REQ-032 rst mid-packet: partial packet abandoned, held output beat discarded; no resume after release.
REQ-033 in_ready is 0 for all channels while rst is high.
REQ-034 Deassertion is assumed synchronous to clk by the integrator; first transfer allowed on first edge after release.

Structure
REQ-035 Package mux_pkg: state enum (IDLE, LOCKED), default N_CH/WIDTH constants, function for SW.
REQ-036 One sub-module stream_reg_slice (WIDTH+1+SW payload, valid/ready, one entry) implements the output register.
REQ-037 Implementation targets 120-400 RTL lines and is Verilator lint-clean (-Wall).

Verification
REQ-038 Reset: rst=1 mid-stream -> all outputs 0 and in_ready=0 same cycle; after release state IDLE.
REQ-039 Single beat: sel=2, in_data ch2=8'hA5, in_valid[2]=1, in_last[2]=1, out_ready=1 -> next cycle out_data=8'hA5, out_ch=2, out_last=1, busy=0.
REQ-040 Lock: ch1 sends 3-beat packet 8'h11,8'h12,8'h13 while sel switches to 3 after beat 1 -> output 11,12,13 all out_ch=1, last only on 13; ch3 accepted only after.
REQ-041 Backpressure: out_ready=0 for 4 cycles with beat 8'h5A held -> out_data stable, in_ready[sel]=0; out_ready=1 -> throughput 1 beat/cycle, no loss.
REQ-042 Invalid select: N_CH=3, sel=3, all in_valid=1 -> in_ready=0, out_valid stays 0.
REQ-043 Parameter sweep: N_CH in {2,4,16}, WIDTH in {1,8,64} with random valid/ready -> scoreboard per-channel order match, packets never interleaved.
